// File: rtl/mem_slave_pkg.sv
// Shared types and defaults for the memory-side FIFO consumer.
package mem_slave_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        POP   = 2'b01,
        LATCH = 2'b10
    } state_t;

endpackage

// File: rtl/mem_slave_ram.sv
// Simple dual-port byte buffer: sync write, registered sync read.
module mem_slave_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk_mem,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Array is never reset; only the read register is.
    always_ff @(posedge clk_mem) begin
        if (we) mem[waddr] <= wdata;
    end

    // Same-address read and write in one cycle returns the old word.
    always_ff @(posedge clk_mem or negedge reset) begin
        if (!reset) rdata <= '0;
        else        rdata <= mem[raddr];
    end

endmodule

// File: rtl/mem_slave.sv
// Pops bytes from the async FIFO read port into a circular buffer (clk_mem domain).
module mem_slave
    import mem_slave_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_mem,
    input  logic              reset,
    input  logic              rx_en,
    input  logic              empty,
    input  logic [DATA_W-1:0] fifo_data_out,
    output logic              r_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W:0]   byte_count,
    output logic              wrapped,
    output logic              busy
);

    localparam int              DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] FULL  = DEPTH[ADDR_W:0];

    state_t state, state_nxt;
    logic   wr_en;

    always_ff @(posedge clk_mem or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Inputs are only looked at in IDLE, so a started pop always completes.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rx_en && !empty) state_nxt = POP;
            POP:     state_nxt = LATCH;
            LATCH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign r_en  = (state == POP);
    assign wr_en = (state == LATCH);
    assign busy  = (state == POP) || (state == LATCH);

    always_ff @(posedge clk_mem or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            byte_count <= '0;
            wrapped    <= 1'b0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (byte_count == FULL) wrapped    <= 1'b1;
            else                    byte_count <= byte_count + 1'b1;
        end
    end

    mem_slave_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_mem (clk_mem),
        .reset   (reset),
        .we      (wr_en),
        .waddr   (wr_ptr),
        .wdata   (fifo_data_out),
        .raddr   (rd_addr),
        .rdata   (rd_data)
    );

endmodule
